mc_port_arbiter: RTL and testbench
==================================

Name: mc_port_arbiter

Overview:
- Shares one memory-controller port (mc_rq_*/mc_rs_*) among NUM_REQ requesters: PDES cores, the history unit and the event-queue spill logic.
- Grants requests round-robin and tags each request's rtnctl with the requester index.
- Routes each response back to its requester by that tag.
- Enforces a per-requester outstanding-request limit and counts arbitration conflicts for the total_q_conf statistic.

Parameters:
- NUM_REQ, 4, number of requesters (power of 2, 2..16); IDX_W = log2(NUM_REQ) is a localparam.
- MC_RTNCTL_WIDTH, 32, rtnctl width at the MC side; the requester-side rtnctl width RW = MC_RTNCTL_WIDTH-IDX_W.
- MAX_OUTST, 8, maximum outstanding requests per requester (1..15).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_rq_vld  in  NUM_REQ  per-requester request valid
- req_rq_cmd  in  3*NUM_REQ  command, slice i = [3i+2:3i]
- req_rq_scmd  in  4*NUM_REQ  sub-command
- req_rq_vadr  in  48*NUM_REQ  virtual address
- req_rq_size  in  2*NUM_REQ  access size
- req_rq_rtnctl  in  RW*NUM_REQ  requester return tag
- req_rq_data  in  64*NUM_REQ  write data
- req_rq_stall  out  NUM_REQ  request not accepted this cycle
- req_rs_vld  out  NUM_REQ  response valid (one-hot or zero)
- req_rs_cmd  out  3  response command (broadcast)
- req_rs_scmd  out  4  response sub-command (broadcast)
- req_rs_rtnctl  out  RW  rtnctl with index bits stripped (broadcast)
- req_rs_data  out  64  response data (broadcast)
- req_rs_stall  in  NUM_REQ  requester cannot accept a response
- mc_rq_vld / mc_rq_cmd / mc_rq_scmd / mc_rq_vadr / mc_rq_size / mc_rq_rtnctl / mc_rq_data  out  1/3/4/48/2/MC_RTNCTL_WIDTH/64  MC request
- mc_rq_flush  out  1  tied to 0
- mc_rq_stall  in  1  MC back-pressure
- mc_rs_vld / mc_rs_cmd / mc_rs_scmd / mc_rs_rtnctl / mc_rs_data  in  1/3/4/MC_RTNCTL_WIDTH/64  MC response
- mc_rs_stall  out  1  response back-pressure to MC
- conf_cnt  out  64  arbitration conflict count

Behaviour:
- Reset (async, rst_n=0):
  - mc_rq_vld=0, all mc_rq_* data fields=0.
  - req_rq_stall = all ones; ptr=0; all outstanding counters=0; conf_cnt=0.
  - Reset mid-transaction drops the held request and all counts. Responses for in-flight requests are not tracked after reset.
- Request path: one output register (OREG).
  - can_load = !mc_rq_vld | !mc_rq_stall.
  - Eligible requester i: req_rq_vld[i] & (outst[i] < MAX_OUTST).
  - When can_load, the winner is the first eligible index scanning ptr, ptr+1, … mod NUM_REQ.
  - On grant of requester g:
    - OREG loads its fields, with mc_rq_rtnctl = {g[IDX_W-1:0], req_rq_rtnctl slice g}.
    - ptr <= g+1 mod NUM_REQ.
    - outst[g] increments.
  - req_rq_stall[i] = !(granted this cycle & i==g). This is combinational from vld/outst/ptr/mc_rq_vld/mc_rq_stall.
  - A requester holds all fields stable while stalled.
  - If nothing is eligible and OREG drains, mc_rq_vld goes to 0 the next cycle.
  - Latency: a request accepted in cycle N appears on mc_rq_* in cycle N+1.
  - Throughput: one request per cycle while mc_rq_stall=0.
  - While mc_rq_stall=1 and mc_rq_vld=1, OREG holds unchanged and no grant is issued.
- Response path: combinational passthrough, with t = mc_rs_rtnctl[MC_RTNCTL_WIDTH-1 -: IDX_W].
  - req_rs_vld[t] = mc_rs_vld & !req_rs_stall[t]; all other bits are 0.
  - mc_rs_stall = mc_rs_vld & req_rs_stall[t].
  - req_rs_rtnctl = mc_rs_rtnctl[RW-1:0]; cmd, scmd and data pass straight through.
  - Response accepted = mc_rs_vld & !mc_rs_stall; it decrements outst[t].
- Every request yields exactly one response (reads and writes).
- Same-cycle grant and response for the same requester leave outst unchanged.
- A response arriving while outst[t]==0 does not decrement; the counter saturates at 0.
- An at-limit requester (outst==MAX_OUTST) is skipped, not waited on.
  - It becomes eligible in the cycle after a response to it is accepted.
  - A response accepted in the same cycle does not make it eligible (the counter is used as registered).
- conf_cnt increments by 1 per cycle in which ≥2 req_rq_vld bits are high and can_load=1, i.e. at least one valid requester loses arbitration. It wraps at 2^64.

Test Plan:
1. Single requester 2, vld for 1 cycle with vadr=0x1000, rtnctl=0x5, MC idle → next cycle mc_rq_vld=1, vadr=0x1000, rtnctl=0x8000_0005; req_rq_stall[2]=0 in the request cycle; outst[2]=1.
2. All 4 requesters held valid, mc_rq_stall=0, ptr=0 → grants in order 0,1,2,3,0,… one per cycle; conf_cnt +1 every cycle.
3. mc_rq_stall=1 for 5 cycles with OREG full → mc_rq_* unchanged for 5 cycles, all req_rq_stall=1, conf_cnt unchanged; first grant on the cycle stall drops.
4. Requester 1 issues 8 requests with no responses → 9th held stalled while requester 3 is still granted; a response with rtnctl=0x4000_0000 → req_rs_vld=4'b0010, next cycle requester 1 granted.
5. Response to requester 0 with req_rs_stall[0]=1 → mc_rs_stall=1, req_rs_vld=0, outst[0] unchanged; release → delivered, outst[0]-1.
6. Assert rst_n=0 with mc_rq_vld=1 and outst nonzero → immediately mc_rq_vld=0, conf_cnt=0; after release, the first grant starts from index 0.

Source files
------------

// File: rtl/mc_port_arbiter_if.sv
// Bundled requester-side and memory-controller-side signals of the MC port arbiter.
// The arbiter binds the slave modport; requesters and the MC model bind master.
interface mc_port_arbiter_if #(
   parameter int NUM_REQ         = 4,
   parameter int MC_RTNCTL_WIDTH = 32
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int RW    = MC_RTNCTL_WIDTH - IDX_W;

   // Handshake rule on every channel: a transfer happens in a cycle where vld=1
   // and the matching stall=0; while stalled the source holds all fields stable.
   logic [NUM_REQ-1:0]         req_rq_vld;
   logic [3*NUM_REQ-1:0]       req_rq_cmd;
   logic [4*NUM_REQ-1:0]       req_rq_scmd;
   logic [48*NUM_REQ-1:0]      req_rq_vadr;
   logic [2*NUM_REQ-1:0]       req_rq_size;
   logic [RW*NUM_REQ-1:0]      req_rq_rtnctl;
   logic [64*NUM_REQ-1:0]      req_rq_data;
   logic [NUM_REQ-1:0]         req_rq_stall;

   logic [NUM_REQ-1:0]         req_rs_vld;
   logic [2:0]                 req_rs_cmd;
   logic [3:0]                 req_rs_scmd;
   logic [RW-1:0]              req_rs_rtnctl;
   logic [63:0]                req_rs_data;
   logic [NUM_REQ-1:0]         req_rs_stall;

   logic                       mc_rq_vld;
   logic [2:0]                 mc_rq_cmd;
   logic [3:0]                 mc_rq_scmd;
   logic [47:0]                mc_rq_vadr;
   logic [1:0]                 mc_rq_size;
   logic [MC_RTNCTL_WIDTH-1:0] mc_rq_rtnctl;
   logic [63:0]                mc_rq_data;
   logic                       mc_rq_flush;
   logic                       mc_rq_stall;

   logic                       mc_rs_vld;
   logic [2:0]                 mc_rs_cmd;
   logic [3:0]                 mc_rs_scmd;
   logic [MC_RTNCTL_WIDTH-1:0] mc_rs_rtnctl;
   logic [63:0]                mc_rs_data;
   logic                       mc_rs_stall;

   logic [63:0]                conf_cnt;

   modport slave (
      input  req_rq_vld, req_rq_cmd, req_rq_scmd, req_rq_vadr, req_rq_size,
             req_rq_rtnctl, req_rq_data, req_rs_stall, mc_rq_stall,
             mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl, mc_rs_data,
      output req_rq_stall, req_rs_vld, req_rs_cmd, req_rs_scmd, req_rs_rtnctl,
             req_rs_data, mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr,
             mc_rq_size, mc_rq_rtnctl, mc_rq_data, mc_rq_flush, mc_rs_stall,
             conf_cnt
   );

   modport master (
      output req_rq_vld, req_rq_cmd, req_rq_scmd, req_rq_vadr, req_rq_size,
             req_rq_rtnctl, req_rq_data, req_rs_stall, mc_rq_stall,
             mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl, mc_rs_data,
      input  req_rq_stall, req_rs_vld, req_rs_cmd, req_rs_scmd, req_rs_rtnctl,
             req_rs_data, mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr,
             mc_rq_size, mc_rq_rtnctl, mc_rq_data, mc_rq_flush, mc_rs_stall,
             conf_cnt
   );
endinterface

// File: rtl/mc_port_arbiter.sv
// Round-robin sharing of one memory-controller port among NUM_REQ requesters,
// with requester-index tagging of rtnctl, response routing and outstanding limits.
module mc_port_arbiter #(
   parameter int NUM_REQ         = 4,
   parameter int MC_RTNCTL_WIDTH = 32,
   parameter int MAX_OUTST       = 8
) (
   input logic              clk,
   input logic              rst_n,
   mc_port_arbiter_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int RW    = MC_RTNCTL_WIDTH - IDX_W;
   localparam int CW    = 4;
   localparam int PW    = $clog2(NUM_REQ + 1);
   localparam logic [CW-1:0] MAX_Q = CW'(MAX_OUTST);

   logic [CW-1:0]              outst_q [NUM_REQ];
   logic [CW-1:0]              outst_d [NUM_REQ];
   logic [IDX_W-1:0]           ptr_q, ptr_d;
   logic [63:0]                conf_q, conf_d;

   logic                       o_vld_q, o_vld_d;
   logic [2:0]                 o_cmd_q, o_cmd_d;
   logic [3:0]                 o_scmd_q, o_scmd_d;
   logic [47:0]                o_vadr_q, o_vadr_d;
   logic [1:0]                 o_size_q, o_size_d;
   logic [MC_RTNCTL_WIDTH-1:0] o_rtnctl_q, o_rtnctl_d;
   logic [63:0]                o_data_q, o_data_d;

   logic                       can_load, found, grant, conflict;
   logic                       rs_acc, rs_tag_stall;
   logic [NUM_REQ-1:0]         eligible, gnt_oh, rs_oh;
   logic [IDX_W-1:0]           gnt_idx, rs_tag;
   logic [31:0]                gi;
   logic [PW-1:0]              vld_cnt;

   // ---------------- request arbitration ----------------
   assign can_load = !o_vld_q || !bus.mc_rq_stall;

   // An at-limit requester is skipped, using the registered count only.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         eligible[i] = bus.req_rq_vld[i] && (outst_q[i] < MAX_Q);
      end
   end

   always_comb begin : rr_pick
      logic [IDX_W-1:0] cand;
      found   = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = ptr_q + IDX_W'(k);
         if (!found && eligible[cand]) begin
            found   = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   // No grant may escape while reset is asserted, so stalls read all ones.
   assign grant  = rst_n && can_load && found;
   assign gnt_oh = grant ? (NUM_REQ'(1) << gnt_idx) : '0;
   assign gi     = 32'(gnt_idx);
   assign bus.req_rq_stall = ~gnt_oh;

   always_comb begin
      vld_cnt = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         vld_cnt = vld_cnt + PW'(bus.req_rq_vld[i]);
      end
   end

   assign conflict = can_load && (vld_cnt >= PW'(2));
   assign conf_d   = conflict ? conf_q + 64'd1 : conf_q;
   assign ptr_d    = grant ? gnt_idx + IDX_W'(1) : ptr_q;

   // ---------------- output register ----------------
   always_comb begin
      o_vld_d    = o_vld_q;
      o_cmd_d    = o_cmd_q;
      o_scmd_d   = o_scmd_q;
      o_vadr_d   = o_vadr_q;
      o_size_d   = o_size_q;
      o_rtnctl_d = o_rtnctl_q;
      o_data_d   = o_data_q;
      if (can_load) begin
         o_vld_d = grant;
         if (grant) begin
            o_cmd_d    = bus.req_rq_cmd[gi*3 +: 3];
            o_scmd_d   = bus.req_rq_scmd[gi*4 +: 4];
            o_vadr_d   = bus.req_rq_vadr[gi*48 +: 48];
            o_size_d   = bus.req_rq_size[gi*2 +: 2];
            o_rtnctl_d = {gnt_idx, bus.req_rq_rtnctl[gi*RW +: RW]};
            o_data_d   = bus.req_rq_data[gi*64 +: 64];
         end
      end
   end

   assign bus.mc_rq_vld    = o_vld_q;
   assign bus.mc_rq_cmd    = o_cmd_q;
   assign bus.mc_rq_scmd   = o_scmd_q;
   assign bus.mc_rq_vadr   = o_vadr_q;
   assign bus.mc_rq_size   = o_size_q;
   assign bus.mc_rq_rtnctl = o_rtnctl_q;
   assign bus.mc_rq_data   = o_data_q;
   assign bus.mc_rq_flush  = 1'b0;
   assign bus.conf_cnt     = conf_q;

   // ---------------- response routing ----------------
   assign rs_tag        = bus.mc_rs_rtnctl[MC_RTNCTL_WIDTH-1 -: IDX_W];
   assign rs_tag_stall  = bus.req_rs_stall[rs_tag];
   assign rs_acc        = bus.mc_rs_vld && !rs_tag_stall;
   assign rs_oh         = rs_acc ? (NUM_REQ'(1) << rs_tag) : '0;

   assign bus.req_rs_vld    = rs_oh;
   assign bus.mc_rs_stall   = bus.mc_rs_vld && rs_tag_stall;
   assign bus.req_rs_cmd    = bus.mc_rs_cmd;
   assign bus.req_rs_scmd   = bus.mc_rs_scmd;
   assign bus.req_rs_rtnctl = bus.mc_rs_rtnctl[RW-1:0];
   assign bus.req_rs_data   = bus.mc_rs_data;

   // Grant and response to the same requester cancel; a stray response saturates at 0.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         outst_d[i] = outst_q[i];
         unique case ({gnt_oh[i], rs_oh[i] && (outst_q[i] != '0)})
            2'b10:   outst_d[i] = outst_q[i] + CW'(1);
            2'b01:   outst_d[i] = outst_q[i] - CW'(1);
            default: outst_d[i] = outst_q[i];
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) outst_q[i] <= '0;
         ptr_q      <= '0;
         conf_q     <= '0;
         o_vld_q    <= 1'b0;
         o_cmd_q    <= '0;
         o_scmd_q   <= '0;
         o_vadr_q   <= '0;
         o_size_q   <= '0;
         o_rtnctl_q <= '0;
         o_data_q   <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) outst_q[i] <= outst_d[i];
         ptr_q      <= ptr_d;
         conf_q     <= conf_d;
         o_vld_q    <= o_vld_d;
         o_cmd_q    <= o_cmd_d;
         o_scmd_q   <= o_scmd_d;
         o_vadr_q   <= o_vadr_d;
         o_size_q   <= o_size_d;
         o_rtnctl_q <= o_rtnctl_d;
         o_data_q   <= o_data_d;
      end
   end
endmodule

// File: tb/tb_mc_port_arbiter.sv
// Randomized and directed bench for mc_port_arbiter against a behavioural model
// of round-robin grant, outstanding limits, response routing and conflict counting.
module tb_mc_port_arbiter;
   localparam int N         = 4;
   localparam int MW        = 32;
   localparam int IDX_W     = 2;
   localparam int RW        = MW - IDX_W;
   localparam int MAX_OUTST = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mc_port_arbiter_if #(.NUM_REQ(N), .MC_RTNCTL_WIDTH(MW)) bus ();

   mc_port_arbiter #(.NUM_REQ(N), .MC_RTNCTL_WIDTH(MW), .MAX_OUTST(MAX_OUTST)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // reference model state
   int          outst_m [N];
   int          ptr_m;
   logic [63:0] conf_m;
   logic        m_vld;
   logic [2:0]  m_cmd;
   logic [3:0]  m_scmd;
   logic [47:0] m_vadr;
   logic [1:0]  m_size;
   logic [MW-1:0] m_rtn;
   logic [63:0] m_data;
   logic [N-1:0] stall_m;
   bit          rs_acc_m;
   logic [MW-1:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick();
      if (m_vld && bus.mc_rq_stall) return -1;
      for (int k = 0; k < N; k++) begin
         int i;
         i = (ptr_m + k) % N;
         if (bus.req_rq_vld[i] && outst_m[i] < MAX_OUTST) return i;
      end
      return -1;
   endfunction

   task automatic drive_idle();
      bus.req_rq_vld    = '0;
      bus.req_rq_cmd    = '0;
      bus.req_rq_scmd   = '0;
      bus.req_rq_vadr   = '0;
      bus.req_rq_size   = '0;
      bus.req_rq_rtnctl = '0;
      bus.req_rq_data   = '0;
      bus.req_rs_stall  = '0;
      bus.mc_rq_stall   = 1'b0;
      bus.mc_rs_vld     = 1'b0;
      bus.mc_rs_cmd     = '0;
      bus.mc_rs_scmd    = '0;
      bus.mc_rs_rtnctl  = '0;
      bus.mc_rs_data    = '0;
   endtask

   task automatic rand_req(input int i);
      bus.req_rq_cmd[i*3 +: 3]     = 3'($urandom);
      bus.req_rq_scmd[i*4 +: 4]    = 4'($urandom);
      bus.req_rq_vadr[i*48 +: 48]  = {16'($urandom), $urandom};
      bus.req_rq_size[i*2 +: 2]    = 2'($urandom);
      bus.req_rq_rtnctl[i*RW +: RW] = RW'($urandom);
      bus.req_rq_data[i*64 +: 64]  = {$urandom, $urandom};
   endtask

   // Called at a negedge with inputs already applied; returns at the next negedge.
   task automatic cycle();
      int w, t, nv;
      bit cl;
      logic [N-1:0] exp_stall, exp_rsv;
      #1;
      w = pick();
      exp_stall = '1;
      if (w >= 0) exp_stall[w] = 1'b0;
      stall_m = exp_stall;
      check("rq_stall", bus.req_rq_stall, exp_stall);
      t = int'(bus.mc_rs_rtnctl[MW-1 -: IDX_W]);
      rs_acc_m = bus.mc_rs_vld && !bus.req_rs_stall[t];
      exp_rsv = '0;
      if (rs_acc_m) exp_rsv[t] = 1'b1;
      check("rs_vld", bus.req_rs_vld, exp_rsv);
      check("mc_rs_stall", bus.mc_rs_stall, bus.mc_rs_vld && bus.req_rs_stall[t]);
      if (bus.mc_rs_vld) begin
         check("rs_rtnctl", bus.req_rs_rtnctl, bus.mc_rs_rtnctl[RW-1:0]);
         check("rs_data", bus.req_rs_data, bus.mc_rs_data);
         check("rs_cmd", {bus.req_rs_cmd, bus.req_rs_scmd}, {bus.mc_rs_cmd, bus.mc_rs_scmd});
      end
      nv = $countones(bus.req_rq_vld);
      cl = !m_vld || !bus.mc_rq_stall;
      @(posedge clk);
      if (m_vld && !bus.mc_rq_stall) exp_q.push_back(m_rtn);
      if (rs_acc_m && outst_m[t] > 0) outst_m[t]--;
      if (nv >= 2 && cl) conf_m++;
      if (cl) begin
         m_vld = (w >= 0);
         if (w >= 0) begin
            m_cmd  = bus.req_rq_cmd[w*3 +: 3];
            m_scmd = bus.req_rq_scmd[w*4 +: 4];
            m_vadr = bus.req_rq_vadr[w*48 +: 48];
            m_size = bus.req_rq_size[w*2 +: 2];
            m_rtn  = {IDX_W'(w), bus.req_rq_rtnctl[w*RW +: RW]};
            m_data = bus.req_rq_data[w*64 +: 64];
            outst_m[w]++;
            ptr_m = (w + 1) % N;
         end
      end
      #1;
      check("mc_rq_vld", bus.mc_rq_vld, m_vld);
      if (m_vld) begin
         check("mc_rq_vadr", bus.mc_rq_vadr, m_vadr);
         check("mc_rq_rtnctl", bus.mc_rq_rtnctl, m_rtn);
         check("mc_rq_data", bus.mc_rq_data, m_data);
         check("mc_rq_ctl", {bus.mc_rq_cmd, bus.mc_rq_scmd, bus.mc_rq_size}, {m_cmd, m_scmd, m_size});
      end
      check("mc_rq_flush", bus.mc_rq_flush, 1'b0);
      check("conf_cnt", bus.conf_cnt, conf_m);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_mc_rq_vld", bus.mc_rq_vld, 1'b0);
      check("rst_conf_cnt", bus.conf_cnt, 64'd0);
      check("rst_rq_stall", bus.req_rq_stall, {N{1'b1}});
      check("rst_mc_rq_vadr", bus.mc_rq_vadr, 48'd0);
      check("rst_mc_rq_rtnctl", bus.mc_rq_rtnctl, 32'd0);
      check("rst_mc_rq_data", bus.mc_rq_data, 64'd0);
      drive_idle();
      for (int i = 0; i < N; i++) outst_m[i] = 0;
      ptr_m = 0; conf_m = '0; m_vld = 1'b0;
      m_cmd = '0; m_scmd = '0; m_vadr = '0; m_size = '0; m_rtn = '0; m_data = '0;
      stall_m = '1; rs_acc_m = 1'b0;
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [N-1:0] es;
      int idx;
      drive_idle();
      @(negedge clk);
      do_reset();

      // single request from requester 2
      bus.req_rq_vld[2] = 1'b1;
      bus.req_rq_vadr[2*48 +: 48] = 48'h1000;
      bus.req_rq_rtnctl[2*RW +: RW] = RW'(5);
      cycle();
      check("t1_vld", bus.mc_rq_vld, 1'b1);
      check("t1_vadr", bus.mc_rq_vadr, 48'h1000);
      check("t1_rtnctl", bus.mc_rq_rtnctl, 32'h8000_0005);
      bus.req_rq_vld = '0;
      cycle();
      check("t1_drain", bus.mc_rq_vld, 1'b0);

      // all four requesters: rotating grants, conflict every cycle
      do_reset();
      for (int i = 0; i < N; i++) bus.req_rq_vadr[i*48 +: 48] = 48'(256 * (i + 1));
      bus.req_rq_vld = '1;
      for (int k = 0; k < 8; k++) begin
         #1;
         es = 4'b1111 ^ (4'b0001 << (k % 4));
         check("t2_grant", bus.req_rq_stall, es);
         cycle();
      end
      check("t2_conf", bus.conf_cnt, 64'd8);

      // MC back-pressure with OREG full
      bus.mc_rq_stall = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cycle();
         check("t3_hold_vadr", bus.mc_rq_vadr, 48'h400);
         check("t3_hold_conf", bus.conf_cnt, 64'd8);
      end
      bus.mc_rq_stall = 1'b0;
      #1;
      check("t3_first_grant", bus.req_rq_stall, 4'b1110);
      cycle();
      check("t3_conf_resume", bus.conf_cnt, 64'd9);
      bus.req_rq_vld = '0;

      // outstanding limit on requester 1
      do_reset();
      bus.req_rq_vld = 4'b0010;
      for (int k = 0; k < MAX_OUTST; k++) cycle();
      bus.req_rq_vld = 4'b1010;
      #1;
      check("t4_limit", bus.req_rq_stall, 4'b0111);
      cycle();
      bus.req_rq_vld[3] = 1'b0;
      bus.mc_rs_vld = 1'b1;
      bus.mc_rs_rtnctl = 32'h4000_0000;
      #1;
      check("t4_rs_route", bus.req_rs_vld, 4'b0010);
      check("t4_still_held", bus.req_rq_stall, 4'b1111);
      cycle();
      bus.mc_rs_vld = 1'b0;
      #1;
      check("t4_regrant", bus.req_rq_stall, 4'b1101);
      cycle();
      bus.req_rq_vld = '0;

      // response back-pressure and counter saturation on requester 0
      bus.req_rq_vld = 4'b0001;
      cycle();
      bus.req_rq_vld = '0;
      bus.mc_rs_vld = 1'b1;
      bus.mc_rs_rtnctl = 32'h0000_0001;
      bus.mc_rs_data = 64'hdead_beef_0123_4567;
      bus.req_rs_stall = 4'b0001;
      #1;
      check("t5_mc_rs_stall", bus.mc_rs_stall, 1'b1);
      check("t5_rs_vld_blocked", bus.req_rs_vld, 4'b0000);
      cycle();
      cycle();
      bus.req_rs_stall = '0;
      #1;
      check("t5_rs_released", bus.req_rs_vld, 4'b0001);
      cycle();
      cycle();
      bus.mc_rs_vld = 1'b0;
      bus.req_rq_vld = 4'b0001;
      #1;
      check("t5_saturate", bus.req_rq_stall, 4'b1110);
      cycle();
      bus.req_rq_vld = '0;
      cycle();

      // randomized traffic against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!(bus.req_rq_vld[i] && stall_m[i])) begin
               bus.req_rq_vld[i] = ($urandom_range(0, 99) < 60);
               rand_req(i);
            end
         end
         bus.mc_rq_stall = ($urandom_range(0, 99) < 25);
         if (!(bus.mc_rs_vld && !rs_acc_m)) begin
            if (exp_q.size() > 0 && $urandom_range(0, 99) < 45) begin
               idx = $urandom_range(0, exp_q.size() - 1);
               bus.mc_rs_rtnctl = exp_q[idx];
               exp_q.delete(idx);
               bus.mc_rs_vld  = 1'b1;
               bus.mc_rs_cmd  = 3'($urandom);
               bus.mc_rs_scmd = 4'($urandom);
               bus.mc_rs_data = {$urandom, $urandom};
            end else begin
               bus.mc_rs_vld = 1'b0;
            end
         end
         for (int i = 0; i < N; i++) bus.req_rs_stall[i] = ($urandom_range(0, 99) < 20);
         cycle();
      end

      // reset in the middle of traffic, then restart from index 0
      do_reset();
      bus.req_rq_vld = '1;
      #1;
      check("t6_restart", bus.req_rq_stall, 4'b1110);
      cycle();
      bus.req_rq_vld = '0;
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
